// File: rtl/mem_retire_buf_pkg.sv
// ---------------------------------------------------------------------------
// mem_retire_buf_pkg
//   Shared core-wide widths used by the memory retire buffer and its
//   neighbours in the pipeline.
//
//   XLEN      data / address width
//   RGBIT     register-index width (register 0 is the "no write" target)
//   MEMB_LEN  maximum number of memory ops the retire buffer may hold
//   MEMB_OFF  width of the pending-op count handed to the exec stage; sized
//             so that it can hold every value 0..MEMB_LEN
// ---------------------------------------------------------------------------
package mem_retire_buf_pkg;

    localparam int XLEN     = 32;
    localparam int RGBIT    = 5;
    localparam int MEMB_LEN = 4;
    localparam int MEMB_OFF = $clog2(MEMB_LEN + 1);

    // Pointer width for a circular buffer; a one-entry buffer still needs a
    // one-bit pointer so that the declaration stays legal.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_retire_buf_if.sv
// ---------------------------------------------------------------------------
// mem_retire_buf_if
//   Bundles the three signal groups of the memory retire buffer:
//     in_*    exec stage -> buffer op handshake (valid/ready)
//     dbus_*  buffer <-> data bus (request/grant, response)
//     mem_*   buffer -> register write-back and pending-op count
//
//   Modports
//     slave   the retire buffer itself
//     master  its environment (exec stage, data bus, write-back)
// ---------------------------------------------------------------------------
interface mem_retire_buf_if #(
    parameter int XLEN = mem_retire_buf_pkg::XLEN
);
    import mem_retire_buf_pkg::*;

    // Exec stage -> buffer
    logic                in_valid;
    logic                in_ready;
    logic                in_load;
    logic [RGBIT-1:0]    in_rd;
    logic [XLEN-1:0]     in_addr;
    logic [XLEN-1:0]     in_wdata;
    logic [XLEN/8-1:0]   in_be;

    // Buffer <-> data bus
    logic                dbus_req;
    logic                dbus_we;
    logic [XLEN-1:0]     dbus_addr;
    logic [XLEN-1:0]     dbus_wdata;
    logic [XLEN/8-1:0]   dbus_be;
    logic                dbus_gnt;
    logic                dbus_rvalid;
    logic [XLEN-1:0]     dbus_rdata;

    // Buffer -> write-back / exec stage
    logic                mem_release;
    logic [RGBIT-1:0]    mem_sel;
    logic [XLEN-1:0]     mem_data;
    logic [MEMB_OFF-1:0] mem_pending;

    modport slave (
        input  in_valid, in_load, in_rd, in_addr, in_wdata, in_be,
        output in_ready,
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_gnt, dbus_rvalid, dbus_rdata,
        output mem_release, mem_sel, mem_data, mem_pending
    );

    modport master (
        output in_valid, in_load, in_rd, in_addr, in_wdata, in_be,
        input  in_ready,
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_gnt, dbus_rvalid, dbus_rdata,
        input  mem_release, mem_sel, mem_data, mem_pending
    );

endinterface

// File: rtl/mem_retire_buf.sv
// ---------------------------------------------------------------------------
// mem_retire_buf
//   In-order memory-op retire buffer. The exec stage pushes loads and stores
//   into a small circular FIFO; the head entry is issued on the data bus one
//   at a time (never a second request before the response of the first), and
//   every response retires the head entry with a one-cycle write-back pulse.
//
// Parameters
//   DEPTH  number of queued ops (power of two, at most MEMB_LEN)
//   XLEN   data / address width
//
// Ports
//   clk    single clock for all state
//   rst    asynchronous, active-low reset
//   bus    mem_retire_buf_if.slave:
//            in_valid/in_ready/in_load/in_rd/in_addr/in_wdata/in_be
//              op handshake from exec; in_ready = (count < DEPTH)
//            dbus_req/we/addr/wdata/be  request built from the head entry,
//              held stable in REQ until dbus_gnt
//            dbus_gnt/dbus_rvalid/dbus_rdata  bus grant and response
//            mem_release/mem_sel/mem_data  registered one-cycle retire pulse
//              (sel = rd and data = load data for loads, both 0 otherwise)
//            mem_pending  ops queued or in flight (the current count)
// ---------------------------------------------------------------------------
module mem_retire_buf #(
    parameter int DEPTH = 4,
    parameter int XLEN  = mem_retire_buf_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    mem_retire_buf_if.slave bus
);
    import mem_retire_buf_pkg::*;

    localparam int PW = ptr_bits(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = XLEN / 8;

    // Bus-side sequencer states, private to this block.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing queued
        ST_REQ  = 2'd1,   // head entry offered on the bus, awaiting grant
        ST_WAIT = 2'd2    // head entry granted, awaiting response
    } state_e;

    typedef struct packed {
        logic            load;
        logic [RGBIT-1:0] rd;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BW-1:0]   be;
    } op_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    op_t              fifo_q [DEPTH];
    op_t              in_op;
    op_t              head_op;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    state_e           state_q,  state_d;

    logic             release_q, release_d;
    logic [RGBIT-1:0] sel_q,     sel_d;
    logic [XLEN-1:0]  data_q,    data_d;

    logic             in_ready;
    logic             push;
    logic             pop;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    // in_ready looks only at the registered count, so a pop in the same
    // cycle never lets a push into a full buffer.
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = bus.in_valid & in_ready;
    // A response only retires an op while one is actually in flight; stray
    // rvalid pulses in IDLE or REQ (including stale ones after reset) are
    // dropped here.
    assign pop      = (state_q == ST_WAIT) & bus.dbus_rvalid;

    always_comb begin
        in_op.load  = bus.in_load;
        in_op.rd    = bus.in_rd;
        in_op.addr  = bus.in_addr;
        in_op.wdata = bus.in_wdata;
        in_op.be    = bus.in_be;
    end

    assign head_op = fifo_q[rd_ptr_q];

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    // NOTE: the entry array carries no reset; count and pointers decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_op;
        end
    end

    // -----------------------------------------------------------------------
    // Count and pointer next-state
    // -----------------------------------------------------------------------
    // NOTE: every variable of a combinational block gets a default on entry,
    // so no path through the block can leave it holding a value (latch).
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;   // idle, or push and pop together
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer: next-state logic
    // -----------------------------------------------------------------------
    // Both IDLE->REQ and WAIT->REQ look at the post-edge count, so an op
    // pushed in the same cycle as the last pop is issued straight away.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.dbus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.dbus_rvalid) begin
                    state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer: outputs
    // -----------------------------------------------------------------------
    // The request fields come straight from the head entry, which cannot
    // change while in REQ (only a pop moves the read pointer), so they stay
    // stable until the grant. Outside REQ the whole request is held at 0.
    always_comb begin
        bus.dbus_req   = 1'b0;
        bus.dbus_we    = 1'b0;
        bus.dbus_addr  = '0;
        bus.dbus_wdata = '0;
        bus.dbus_be    = '0;
        if (state_q == ST_REQ) begin
            bus.dbus_req   = 1'b1;
            bus.dbus_we    = ~head_op.load;
            bus.dbus_addr  = head_op.addr;
            bus.dbus_wdata = head_op.wdata;
            bus.dbus_be    = head_op.be;
        end
    end

    // -----------------------------------------------------------------------
    // Retire pulse
    // -----------------------------------------------------------------------
    // Stores and loads to register 0 still retire, but select no register,
    // so nothing downstream is written.
    always_comb begin
        release_d = pop;
        sel_d     = '0;
        data_d    = '0;
        if (pop && head_op.load) begin
            sel_d  = head_op.rd;
            data_d = bus.dbus_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Count, pointers and retire registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            release_q <= 1'b0;
            sel_q     <= '0;
            data_q    <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            release_q <= release_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.in_ready    = in_ready;
    assign bus.mem_release = release_q;
    assign bus.mem_sel     = sel_q;
    assign bus.mem_data    = data_q;
    assign bus.mem_pending = MEMB_OFF'(count_q);

endmodule

// File: doc/mem_retire_buf.md
MEM_RETIRE_BUF -- requirements
Module: mem_retire_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queued memory ops, power of two.
REQ-002 SHALL have parameter XLEN, default 32: data/address width.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  exec stage offers a memory op.
REQ-006 SHALL have port in_ready  output  1  buffer can accept an op.
REQ-007 SHALL have port in_load  input  1  1=load, 0=store.
REQ-008 SHALL have port in_rd  input  RGBIT  load destination register; ignored for stores.
REQ-009 SHALL have port in_addr  input  XLEN  byte address.
REQ-010 SHALL have port in_wdata  input  XLEN  store data.
REQ-011 SHALL have port in_be  input  XLEN/8  byte enables.
REQ-012 SHALL have port dbus_req  output  1  data-bus request.
REQ-013 SHALL have port dbus_we  output  1  write request.
REQ-014 SHALL have ports dbus_addr / dbus_wdata  output  XLEN  request address / data.
REQ-015 SHALL have port dbus_be  output  XLEN/8  request byte enables.
REQ-016 SHALL have port dbus_gnt  input  1  request accepted.
REQ-017 SHALL have port dbus_rvalid  input  1  response (load data or store ack).
REQ-018 SHALL have port dbus_rdata  input  XLEN  load data.
REQ-019 SHALL have port mem_release  output  1  one memory op retired this cycle.
REQ-020 SHALL have port mem_sel  output  RGBIT  register written; 0 = no write.
REQ-021 SHALL have port mem_data  output  XLEN  write-back value.
REQ-022 SHALL have port mem_pending  output  MEMB_OFF  ops queued or in flight; exec stage uses it to tag rg_cnt.

Function
REQ-023 SHALL store ops in a circular FIFO of DEPTH entries (load, rd, addr, wdata, be) and push on in_valid & in_ready.
REQ-024 SHALL drive in_ready = (count < DEPTH); a pop in the same cycle does not raise in_ready.
REQ-025 SHALL run a three-state FSM: IDLE, REQ, WAIT.
REQ-026 SHALL go IDLE->REQ on the clock edge where count becomes non-zero.
REQ-027 SHALL hold dbus_req=1 in REQ, with dbus_we=~load and addr/wdata/be taken from the head entry, all stable until dbus_gnt.
REQ-028 SHALL go REQ->WAIT on dbus_gnt and deassert dbus_req in WAIT.
REQ-029 SHALL, on dbus_rvalid in WAIT, pop the head entry and go to REQ if count after the pop is non-zero, otherwise to IDLE.
REQ-030 SHALL ignore dbus_rvalid in IDLE and REQ.
REQ-031 SHALL register mem_release=1 for exactly one cycle, the cycle after each pop.
REQ-032 SHALL, in that cycle, drive mem_sel=rd and mem_data=dbus_rdata for loads, and mem_sel=0 and mem_data=0 for stores; both are 0 in all other cycles.
REQ-033 SHALL treat a load with rd=0 as a retire: mem_release=1, mem_sel=0.
REQ-034 SHALL keep count unchanged on a simultaneous push and pop.
REQ-035 SHALL wrap the read and write pointers modulo DEPTH.
REQ-036 SHALL drive mem_pending = count, including the in-flight head entry.
REQ-037 SHALL never issue a second request before the current response arrives: ops complete strictly in order.

Reset
REQ-038 SHALL, while rst=0, clear count, pointers, FSM (to IDLE), dbus_req, mem_release, mem_sel and mem_data; the other dbus outputs are 0.
REQ-039 SHALL, on reset mid-operation, drop any outstanding response, and SHALL ignore a dbus_rvalid arriving after reset release.
REQ-040 SHALL have in_ready=1 on the first cycle after reset release.

Structure
REQ-041 SHALL take XLEN, RGBIT and MEMB_OFF from the shared define header, and SHALL add MEMB_LEN there with MEMB_OFF >= clog2(MEMB_LEN+1).
REQ-042 SHALL define the FSM state encodings locally in this module.
REQ-043 SHALL be a single module with no sub-modules; the FIFO storage is inline.

Verification
REQ-044 Single load (rd=5, addr=0x100); gnt in cycle 2; rvalid with rdata=0xDEADBEEF in cycle 4 -> mem_release=1, mem_sel=5, mem_data=0xDEADBEEF in cycle 5; mem_pending back to 0.
REQ-045 Store (addr=0x200, wdata=0x12345678, be=0xF) -> dbus_we=1 with those values held until gnt; after rvalid, mem_release=1 with mem_sel=0.
REQ-046 Fill: five back-to-back pushes with gnt low -> in_ready=0 after the 4th push, mem_pending=4, and the 5th push is held off until the first pop.
REQ-047 Push in the same cycle as a pop, at count=2 -> count stays 2; a later 6-op sequence passes through the pointer wrap with retire order and data matching the push order.
REQ-048 rst=0 asserted in WAIT with one op in flight, then a stale rvalid after release -> no mem_release, mem_pending=0, FSM in IDLE.
REQ-049 Load with rd=0 -> mem_release=1, mem_sel=0, and no register corrupted downstream.
